sc_multipoint_ctrl: RTL
=======================

// Module: sc_multipoint_ctrl
// PURPOSE
//  Parametrised N-player point/car position controller for the LED-matrix game core. Holds one one-hot
//  position register per player, moved by debounced left/right buttons, with a start/pause FSM, an
//  optional auto-repeat on held buttons, a wrap/saturate mode and a per-player move counter.
//  Its outputs feed the matrix column mux and the BIN2BCD/7-seg score path.
// PARAMETERS
//  WIDTH          8    positions per lane (bits of each one-hot position register), >=2
//  PLAYERS        2    independent players/lanes, >=1
//  INIT_POS       0    bit index loaded into every lane on game start, 0..WIDTH-1
//  WRAP           0    0: saturate at lane edges; 1: wrap to the opposite edge
//  REPEAT_CYCLES  0    held-button auto-repeat period in clocks; 0 disables repeat
//  CNT_W          8    width of each per-player move counter
// PORTS
//  SC_MULTIPOINT_CTRL_CLOCK_50       in   1              system clock, rising edge
//  SC_MULTIPOINT_CTRL_RESET_InLow    in   1              asynchronous, active-low reset
//  SC_MULTIPOINT_CTRL_start_InLow    in   1              debounced start/pause button, 0 = pressed
//  SC_MULTIPOINT_CTRL_left_InLow     in   PLAYERS        debounced left buttons, bit p = player p, 0 = pressed
//  SC_MULTIPOINT_CTRL_right_InLow    in   PLAYERS        debounced right buttons, bit p = player p, 0 = pressed
//  SC_MULTIPOINT_CTRL_pos_OutBUS     out  PLAYERS*WIDTH  one-hot positions; player p at [p*WIDTH +: WIDTH]
//  SC_MULTIPOINT_CTRL_edge_OutBUS    out  PLAYERS        1 when player p sits at bit 0 or bit WIDTH-1
//  SC_MULTIPOINT_CTRL_moves_OutBUS   out  PLAYERS*CNT_W  moves made per player; player p at [p*CNT_W +: CNT_W]
//  SC_MULTIPOINT_CTRL_state_Out      out  2              FSM state: 00 IDLE, 01 LOAD, 10 PLAY, 11 PAUSE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, pos=0, moves=0, edge=0, all edge/repeat regs cleared.
//  - Press = falling edge of the *_InLow input, detected against a 1-cycle-delayed copy (reset value 1).
//  - FSM: IDLE -start press-> LOAD (1 cycle) -> PLAY; PLAY -start press-> PAUSE; PAUSE -start press-> PLAY.
//    No path back to IDLE except reset.
//  - IDLE: pos=0, moves hold. LOAD: every lane pos = 1<<INIT_POS, moves=0.
//  - PLAY, per lane, single move step:
//    - left press: pos shifts toward MSB (index+1).
//    - right press: pos shifts toward LSB (index-1).
//    - New pos is visible on the clock edge that samples the press (1-cycle latency from input change).
//  - Simultaneous left and right (both pressed or both edges in one cycle): no move, repeat counter cleared.
//  - Edge of lane:
//    - WRAP=0: a move past bit WIDTH-1/bit 0 is blocked; pos and moves hold.
//    - WRAP=1: bit WIDTH-1 goes to bit 0 on left, and bit 0 goes to bit WIDTH-1 on right; counts as a move.
//  - Auto-repeat (REPEAT_CYCLES>0): while exactly one direction stays held after its press, a counter
//    runs. Each time it reaches REPEAT_CYCLES-1, it issues one extra step and restarts. Release or
//    leaving PLAY clears it.
//  - moves[p] increments by 1 only on an actual position change and saturates at 2^CNT_W-1.
//  - PAUSE: pos and moves frozen; left/right ignored; repeat counters held cleared.
//  - A start press in PLAY/PAUSE takes priority over lane moves in the same cycle (no move that cycle).
//  - edge_OutBUS is combinational from the registered pos (0 in IDLE).
//  - Lanes are fully independent; all players may move in the same cycle.
// STRUCTURE
//  - Package sc_multipoint_pkg: state encoding localparams (ST_IDLE..ST_PAUSE), a default WIDTH/CNT_W,
//    and a function onehot_shift(pos, dir, wrap).
//  - Sub-module sc_point_lane: one per player, built with a generate loop. It holds the edge detect,
//    repeat counter, position register, move counter and edge flag.
//  - Top level: start edge detect, FSM, bus packing.
// TESTING
//  1. Reset low mid-PLAY with pos=8'h10 -> all outputs 0, state=00 immediately; release, press start ->
//     LOAD, then PLAY with pos=8'h01 per lane and moves=0.
//  2. WRAP=0, player0 at 8'h80, left press -> pos stays 8'h80, moves unchanged, edge[0]=1; right press ->
//     8'h40, moves+1.
//  3. WRAP=1, player1 at 8'h01, right press -> 8'h80, moves[1]+1, edge[1]=1.
//  4. REPEAT_CYCLES=4, left held 13 cycles from 8'h01 -> 8'h02 at press, then 8'h04, 8'h08, 8'h10 every
//     4 clocks; release stops.
//  5. Left and right pressed in the same cycle -> no move. Start pressed with left in PLAY -> PAUSE, pos
//     unchanged; lane presses in PAUSE are ignored.
//  6. CNT_W=2, seven valid moves -> moves saturates at 3; two players move in the same cycle -> both
//     update independently.

Source files
------------

// File: rtl/sc_multipoint_pkg.sv
// Shared types and helpers for the multi-player point controller.
package sc_multipoint_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_PLAY  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // Widest lane the shift helper can handle; lanes pad their position up to this.
    localparam int MAX_WIDTH = 64;
    localparam int IDX_W     = $clog2(MAX_WIDTH);

    localparam logic DIR_LEFT  = 1'b1;   // toward MSB
    localparam logic DIR_RIGHT = 1'b0;   // toward LSB

    // One step of a one-hot position inside a lane whose top bit is msbIdx.
    // At an edge the position either holds (wrap=0) or jumps to the far edge (wrap=1).
    function automatic logic [MAX_WIDTH-1:0] onehot_shift(
        input logic [MAX_WIDTH-1:0] pos,
        input logic                 dir,
        input logic                 wrap,
        input logic [IDX_W-1:0]     msbIdx
    );
        logic [MAX_WIDTH-1:0] res;
        res = pos;
        if (dir == DIR_LEFT) begin
            if (pos[msbIdx]) begin
                if (wrap) begin
                    res    = '0;
                    res[0] = 1'b1;
                end
            end else begin
                res = pos << 1;
            end
        end else begin
            if (pos[0]) begin
                if (wrap) begin
                    res         = '0;
                    res[msbIdx] = 1'b1;
                end
            end else begin
                res = pos >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sc_multipoint_ctrl_lane.sv
// One player lane: button edge detect, auto-repeat, one-hot position, move counter, edge flag.
module sc_point_lane
    import sc_multipoint_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int INIT_POS      = 0,
    parameter int WRAP          = 0,
    parameter int REPEAT_CYCLES = 0,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             isIdle,
    input  logic             isLoad,
    input  logic             isPlay,
    input  logic             startPress,
    input  logic             leftN,
    input  logic             rightN,
    output logic [WIDTH-1:0] pos,
    output logic [CNT_W-1:0] moves,
    output logic             edgeFlag
);

    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INIT_ONEHOT = WIDTH'(1) << INIT_POS;
    localparam logic             RPT_EN   = (REPEAT_CYCLES > 0);

    // Saturating +1 so the score display never rolls over to zero.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic                 leftDly, rightDly;
    logic                 leftPress, rightPress, leftHeld, rightHeld;
    logic                 laneActive;
    logic [RPT_W-1:0]     rptCnt, rptCntNext;
    logic                 rptOn, rptOnNext;
    logic                 rptDir, rptDirNext;
    logic                 stepReq, stepDir;
    logic [MAX_WIDTH-1:0] posWide, shiftWide;
    logic [WIDTH-1:0]     nextPos;
    logic                 moved;

    assign edgeFlag = pos[0] | pos[WIDTH-1];

    // Decide whether this cycle issues a step (fresh press or repeat tick) and advance the repeat state.
    always_comb begin
        leftHeld   = ~leftN;
        rightHeld  = ~rightN;
        leftPress  = leftDly & leftHeld;
        rightPress = rightDly & rightHeld;
        laneActive = isPlay & ~startPress;
        stepReq    = 1'b0;
        stepDir    = DIR_RIGHT;
        rptCntNext = rptCnt;
        rptOnNext  = rptOn;
        rptDirNext = rptDir;
        if (!laneActive || (leftHeld && rightHeld)) begin
            rptCntNext = '0;
            rptOnNext  = 1'b0;
        end else if (leftPress || rightPress) begin
            stepReq    = 1'b1;
            stepDir    = leftPress ? DIR_LEFT : DIR_RIGHT;
            rptCntNext = '0;
            rptOnNext  = RPT_EN;
            rptDirNext = leftPress ? DIR_LEFT : DIR_RIGHT;
        end else if (rptOn && ((rptDir == DIR_LEFT) ? leftHeld : rightHeld)) begin
            if (rptCnt == RPT_LAST) begin
                stepReq    = 1'b1;
                stepDir    = rptDir;
                rptCntNext = '0;
            end else begin
                rptCntNext = rptCnt + RPT_W'(1);
            end
        end else begin
            rptCntNext = '0;
            rptOnNext  = 1'b0;
        end
    end

    // Compute the candidate position; a blocked edge move leaves it unchanged and is not counted.
    always_comb begin
        posWide              = '0;
        posWide[WIDTH-1:0]   = pos;
        shiftWide            = onehot_shift(posWide, stepDir, (WRAP != 0), MSB_IDX);
        nextPos              = shiftWide[WIDTH-1:0];
        moved                = stepReq && (shiftWide != posWide);
    end

    // Lane registers: edge-detect history, repeat state, position and move count.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            leftDly  <= 1'b1;
            rightDly <= 1'b1;
            rptCnt   <= '0;
            rptOn    <= 1'b0;
            rptDir   <= DIR_RIGHT;
            pos      <= '0;
            moves    <= '0;
        end else begin
            leftDly  <= leftN;
            rightDly <= rightN;
            rptCnt   <= rptCntNext;
            rptOn    <= rptOnNext;
            rptDir   <= rptDirNext;
            if (isIdle) begin
                pos <= '0;
            end else if (isLoad) begin
                pos   <= INIT_ONEHOT;
                moves <= '0;
            end else if (moved) begin
                pos   <= nextPos;
                moves <= satInc(moves);
            end
        end
    end

endmodule

// File: rtl/sc_multipoint_ctrl.sv
// N-player position controller: start/pause FSM plus one lane per player.
module sc_multipoint_ctrl
    import sc_multipoint_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int PLAYERS       = 2,
    parameter int INIT_POS      = 0,
    parameter int WRAP          = 0,
    parameter int REPEAT_CYCLES = 0,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                       SC_MULTIPOINT_CTRL_CLOCK_50,
    input  logic                       SC_MULTIPOINT_CTRL_RESET_InLow,
    input  logic                       SC_MULTIPOINT_CTRL_start_InLow,
    input  logic [PLAYERS-1:0]         SC_MULTIPOINT_CTRL_left_InLow,
    input  logic [PLAYERS-1:0]         SC_MULTIPOINT_CTRL_right_InLow,
    output logic [PLAYERS*WIDTH-1:0]   SC_MULTIPOINT_CTRL_pos_OutBUS,
    output logic [PLAYERS-1:0]         SC_MULTIPOINT_CTRL_edge_OutBUS,
    output logic [PLAYERS*CNT_W-1:0]   SC_MULTIPOINT_CTRL_moves_OutBUS,
    output logic [1:0]                 SC_MULTIPOINT_CTRL_state_Out
);

    state_t state;
    logic   startDly;
    logic   startPress;

    assign startPress                   = startDly & ~SC_MULTIPOINT_CTRL_start_InLow;
    assign SC_MULTIPOINT_CTRL_state_Out = state;

    // Start edge detect and game FSM; only reset returns to IDLE.
    always_ff @(posedge SC_MULTIPOINT_CTRL_CLOCK_50 or negedge SC_MULTIPOINT_CTRL_RESET_InLow) begin
        if (!SC_MULTIPOINT_CTRL_RESET_InLow) begin
            state    <= ST_IDLE;
            startDly <= 1'b1;
        end else begin
            startDly <= SC_MULTIPOINT_CTRL_start_InLow;
            unique case (state)
                ST_IDLE:  if (startPress) state <= ST_LOAD;
                ST_LOAD:  state <= ST_PLAY;
                ST_PLAY:  if (startPress) state <= ST_PAUSE;
                ST_PAUSE: if (startPress) state <= ST_PLAY;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : gLane
        sc_point_lane #(
            .WIDTH         (WIDTH),
            .INIT_POS      (INIT_POS),
            .WRAP          (WRAP),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (CNT_W)
        ) uLane (
            .clk        (SC_MULTIPOINT_CTRL_CLOCK_50),
            .rstN       (SC_MULTIPOINT_CTRL_RESET_InLow),
            .isIdle     (state == ST_IDLE),
            .isLoad     (state == ST_LOAD),
            .isPlay     (state == ST_PLAY),
            .startPress (startPress),
            .leftN      (SC_MULTIPOINT_CTRL_left_InLow[p]),
            .rightN     (SC_MULTIPOINT_CTRL_right_InLow[p]),
            .pos        (SC_MULTIPOINT_CTRL_pos_OutBUS[p*WIDTH +: WIDTH]),
            .moves      (SC_MULTIPOINT_CTRL_moves_OutBUS[p*CNT_W +: CNT_W]),
            .edgeFlag   (SC_MULTIPOINT_CTRL_edge_OutBUS[p])
        );
    end

endmodule
